// File: rtl/ahbuart_rx_frontend.sv
// Serial receive front-end for ahbuart: line synchronizer, 8N1 mid-bit frame
// recovery, FWFT receive FIFO with valid/ready output, framing/overrun flags.
module ahbuart_rx_frontend #(
  parameter int unsigned DIVISOR    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uarti,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr
);

  localparam int unsigned CW = $clog2(DIVISOR);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic          sync1_q, sync1_d;
  logic          rxs_q, rxs_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic push, pop, push_ok, empty, full, expired;

  // Frame recovery: counter reloads at each sample so samples land mid-bit
  always_comb begin
    sync1_d     = uarti;
    rxs_d       = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    expired     = (cnt_q == '0);
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs_q) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          cnt_d   = FULL_M1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          sh_d  = {rxs_q, sh_q[7:1]};
          cnt_d = FULL_M1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs_q) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && rx_ready;
    push_ok   = push && (!full || pop);
    wr_ptr_d  = wr_ptr_q + PW'(push_ok);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    mem_d     = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = sh_q;
    end
    overrun_d = (push && !push_ok) || (overrun_q && !ovr_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      sh_q        <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign rx_valid  = !empty;
  assign rx_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ahbuart_rx_frontend.sv
// Directed bench for ahbuart_rx_frontend: 8N1 frames in, popped bytes checked
// against a scoreboard queue, flags and latency checked at fixed points.
module tb_ahbuart_rx_frontend;

  localparam int unsigned D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uarti;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       ovr_clr;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int valid_cnt = 0;
  int fe_cnt   = 0;
  logic valid_prev = 1'b0;
  logic [7:0] sb [$];

  ahbuart_rx_frontend #(.DIVISOR(D), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .uarti(uarti), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Output monitor: pops are compared against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) valid_cnt++;
      if (rx_valid && !valid_prev) rise_cyc = cyc_cnt;
      if (frame_err) fe_cnt++;
      if (rx_valid && rx_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL pop_unexpected observed=%02h expected=none", rx_data);
        end
        if (sb.size() > 0) begin
          logic [7:0] exp_b;
          exp_b = sb.pop_front();
          checks++;
          assert (rx_data === exp_b) else begin
            failures++;
            $error("FAIL pop_data observed=%02h expected=%02h", rx_data, exp_b);
          end
        end
      end
    end
    valid_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame; rx_ready pulses high in frame cycle rdy_off if non-negative
  task automatic send(input logic [7:0] b, input logic stop, input logic rdy, input int rdy_off);
    for (int k = 0; k < 10 * D; k++) begin
      int bi;
      bi = k / D;
      if (k == 0) fall_cyc = cyc_cnt;
      if (bi == 0)      uarti = 1'b0;
      else if (bi <= 8) uarti = b[bi-1];
      else              uarti = stop;
      rx_ready = (k == rdy_off) ? 1'b1 : rdy;
      cyc(1);
    end
    rx_ready = rdy;
  endtask

  initial begin
    int fe0, vc0;
    reset = 1'b1; uarti = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    cyc(2 * D);

    // Single byte with latency from the line falling edge
    valid_cnt = 0;
    sb.push_back(8'h55);
    send(8'h55, 1'b1, 1'b1, -1);
    cyc(D);
    chk("single_latency", 32'(rise_cyc - fall_cyc), 32'd155);
    chk("single_valid_cycles", 32'(valid_cnt), 32'd1);
    chk("single_ferr", 32'(fe_cnt), 32'd0);
    chk("single_ovr", 32'(overrun), 32'd0);
    chk("single_sb", 32'(sb.size()), 32'd0);

    // Start-bit glitch, then a good frame
    vc0 = valid_cnt;
    uarti = 1'b0; cyc(4); uarti = 1'b1; cyc(2 * D);
    chk("glitch_valid", 32'(valid_cnt - vc0), 32'd0);
    sb.push_back(8'hA3);
    send(8'hA3, 1'b1, 1'b1, -1);
    cyc(D);
    chk("glitch_next_sb", 32'(sb.size()), 32'd0);

    // Framing error followed by a long break
    fe0 = fe_cnt;
    vc0 = valid_cnt;
    send(8'h0F, 1'b0, 1'b1, -1);
    cyc(40 * D);
    uarti = 1'b1;
    cyc(2 * D);
    chk("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_no_byte", 32'(valid_cnt - vc0), 32'd0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b1, -1);
    cyc(D);
    chk("ferr_after_pulses", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_after_sb", 32'(sb.size()), 32'd0);

    // Overrun: five frames into a 4-deep FIFO with no consumer
    rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) sb.push_back(8'(v));
      send(8'(v), 1'b1, 1'b0, -1);
      if (v == 4) chk("ovr_before", 32'(overrun), 32'd0);
    end
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_head", 32'(rx_data), 32'h01);
    rx_ready = 1'b1; cyc(8); rx_ready = 1'b0;
    chk("ovr_drained_valid", 32'(rx_valid), 32'd0);
    chk("ovr_drained_sb", 32'(sb.size()), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1; cyc(1); ovr_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Push into full FIFO in the same cycle as a pop
    for (int v = 1; v <= 5; v++) sb.push_back(8'(v));
    for (int v = 1; v <= 4; v++) send(8'(v), 1'b1, 1'b0, -1);
    send(8'h05, 1'b1, 1'b0, 154);
    chk("pp_no_ovr", 32'(overrun), 32'd0);
    chk("pp_head", 32'(rx_data), 32'h02);
    rx_ready = 1'b1; cyc(8); rx_ready = 1'b0;
    chk("pp_sb", 32'(sb.size()), 32'd0);
    chk("pp_valid", 32'(rx_valid), 32'd0);

    // Reset in the middle of a frame with one byte buffered
    send(8'h5A, 1'b1, 1'b0, -1);
    chk("mid_buffered", 32'(rx_data), 32'h5A);
    uarti = 1'b0; cyc(D);
    uarti = 1'b1; cyc(4 * D + 8);
    reset = 1'b1; #1;
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'h00);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(2 * D);
    vc0 = valid_cnt;
    sb.push_back(8'h81);
    send(8'h81, 1'b1, 1'b1, -1);
    cyc(D);
    chk("mid_after_sb", 32'(sb.size()), 32'd0);
    chk("mid_after_count", 32'(valid_cnt - vc0), 32'd1);
    chk("mid_after_valid", 32'(rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahbuart_rx_frontend.md
# ahbuart_rx_frontend

Serial receive front-end that sits directly upstream of `ahbuart` on the `uarti` path. It synchronizes the raw serial line and recovers 8N1 frames with a mid-bit sampling counter. Received bytes are buffered in a small first-word-fall-through FIFO and presented to the downstream command decoder over a valid/ready handshake. It also flags framing errors and overruns.

## Interface
- `DIVISOR`, default 16: clock cycles per serial bit; even, minimum 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of 2, minimum 2.

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `uarti`  in  1  raw asynchronous serial line; idle high.
- `rx_data`  out  8  byte at the FIFO head; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte when `rx_valid`=1 and `rx_ready`=1.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples 0.
- `overrun`  out  1  sticky; set when a completed byte is dropped because the FIFO is full.
- `ovr_clr`  in  1  clears `overrun`.

## Operation
- **Synchronizer:** 2-flop synchronizer on `uarti` gives `rxs`. Both flops reset to 1.
- **Frame FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. There is one bit counter (0–7) and one cycle counter of width clog2(DIVISOR).
- **IDLE:** when `rxs`=0, go to START and load the cycle counter for DIVISOR/2 cycles.
- **START:** at expiry, sample `rxs`.
  - `rxs`=0: go to DATA with bit counter 0 and a cycle count of DIVISOR.
  - `rxs`=1: glitch; return to IDLE with no output.
- **DATA:** at each expiry, shift `rxs` into the shift register LSB-first. After bit 7, go to STOP with a cycle count of DIVISOR.
- **STOP:** at expiry, sample `rxs`.
  - `rxs`=1: push the byte and go to IDLE.
  - `rxs`=0: pulse `frame_err`, discard the byte and go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rxs`=1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A push and pop in the same cycle on an empty FIFO: no pop occurs (`rx_valid`=0), and the push is accepted.
  - A rejected push sets `overrun`. The dropped byte is lost and the FIFO contents are unchanged.
- **`overrun` clear:** `ovr_clr` clears `overrun`. If a new overrun occurs in the same cycle as `ovr_clr`, the set wins.
- **Outputs:** `rx_data` is driven by the head entry. `rx_data` is don't-care when empty, but must be stable while `rx_valid`=1 and no pop occurs.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0. State is IDLE, FIFO is empty, synchronizer flops are 1.
- **Reset mid-frame:** the partial byte is discarded and FIFO contents are lost. Reception resumes on the next start bit after reset deasserts.
- **Input delay:** an `uarti` edge reaches `rxs` 2 cycles later.
- **Sample points:** let T0 be the first cycle in IDLE with `rxs`=0.
  - Start bit: T0+DIVISOR/2.
  - Data bit i: T0+DIVISOR/2+(i+1)·DIVISOR.
  - Stop bit: Ts = T0+DIVISOR/2+9·DIVISOR.
- **Outputs after the stop-bit sample (cycle Ts):**
  - Into an empty FIFO, `rx_valid`=1 in cycle Ts+1.
  - `frame_err` is high during cycle Ts+1 only.
  - `overrun` is set in cycle Ts+1.
- **Back-to-back frames:** IDLE is re-entered at Ts+1. A start bit immediately following the stop bit is detected with no lost frame.
- **Pop:** when `rx_valid`=1 and `rx_ready`=1 at a rising edge, the pop takes effect at that edge. The next entry, or `rx_valid`=0, is visible in the following cycle.
- **Throughput:** one byte per cycle through the handshake. `rx_valid` must not depend combinationally on `rx_ready`.

## Test plan
- **Single byte:** DIVISOR=16, send 0x55 8N1 with `rx_ready`=1 -> `rx_valid` is high for exactly 1 cycle with `rx_data`=0x55, 2+8+144+1 cycles after the `uarti` falling edge. `frame_err`=0 and `overrun`=0.
- **Start-bit glitch:** drive `uarti` low for 4 cycles, then high -> no `rx_valid`, FSM back in IDLE. A subsequent 0xA3 frame is received correctly.
- **Framing error:** send 0x0F with stop bit 0, hold line low for 40 bit-times, then idle, then send 0x3C -> one `frame_err` pulse, no byte for 0x0F, a single 0x3C delivered.
- **Overrun:** `rx_ready`=0, send 0x01..0x05 back-to-back with FIFO_DEPTH=4 -> `overrun`=1 after the fifth stop bit. Draining yields 0x01,0x02,0x03,0x04, then `rx_valid`=0. `ovr_clr` then returns `overrun` to 0.
- **Simultaneous push and pop:** FIFO full, `rx_ready`=1 in the cycle the fifth byte completes -> no overrun, all five bytes delivered in order.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0xFF with one byte already buffered -> all outputs return to reset values immediately. After release, a following 0x81 is received as the only byte.
